// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: walks one instruction through fetch, decode,
// execute and writeback over a shared datapath. Optional jump support via MIPS_JUMP_EN.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [2:0] aluop,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_REX     = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_IEX     = 4'd8;
  localparam logic [3:0] S_IWB     = 4'd9;
  localparam logic [3:0] S_ILLEGAL = 4'd10;
`ifdef MIPS_JUMP_EN
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [5:0] OP_J      = 6'b000010;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_ADDU  = 6'b100001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ORI = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b000;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  logic       r_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RESET_STATE;
      r_op      <= 6'd0;
      r_funct   <= 6'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= op;
        r_funct <= funct;
      end
      if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_RTYPE:                 w_next = (funct == FN_ADDU) ? S_REX : S_ILLEGAL;
          OP_ADDIU, OP_ORI, OP_LUI: w_next = S_IEX;
`ifdef MIPS_JUMP_EN
          OP_J:                     w_next = S_JUMP;
`endif
          default:                  w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   if (mem_ready) w_next = S_FETCH;
      // Latched funct is rechecked so a corrupted decode cannot retire a bogus R-type.
      S_REX:     w_next = (r_funct == FN_ADDU) ? S_RWB : S_ILLEGAL;
      S_RWB:     w_next = S_FETCH;
      S_IEX:     w_next = S_IWB;
      S_IWB:     w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
`ifdef MIPS_JUMP_EN
      S_JUMP:    w_next = S_FETCH;
`endif
      default:   w_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_sel    = 1'b0;
    aluop      = 3'b000;
    retire     = 1'b0;
    illegal    = 1'b0;
    state_o    = 4'd0;
    if (!reset) begin
      state_o = r_state;
      illegal = r_illegal;
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          aluop     = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          retire  = mem_ready;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          aluop     = ALU_ADD;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (r_op)
            OP_ORI:  begin ext_sel = 1'b1; aluop = ALU_ORI; end
            OP_LUI:  begin ext_sel = 1'b1; aluop = ALU_LUI; end
            default: aluop = ALU_ADD;
          endcase
        end
        S_IWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
`ifdef MIPS_JUMP_EN
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl; each row is one clock of
// inputs with the full output vector expected mid-cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_sel;
  logic [2:0] aluop;
  logic       retire, illegal;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .aluop(aluop), .retire(retire), .illegal(illegal),
    .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [2:0] aluop;
    logic       retire, illegal;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mrdy;
    outs_t      exp;
    string      name;
  } vec_t;

  //                          st     rq we io ir pc  src   rw rd mr sa  sb    ex alu     rt il
  localparam outs_t O_ZERO  = {4'd0, 5'b00000, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam outs_t O_FW    = {4'd0, 5'b10000, 2'b00, 4'b0000, 2'b01, 1'b0, 3'b010, 2'b00};
  localparam outs_t O_FG    = {4'd0, 5'b10011, 2'b00, 4'b0000, 2'b01, 1'b0, 3'b010, 2'b00};
  localparam outs_t O_DEC   = {4'd1, 5'b00000, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam outs_t O_MADR  = {4'd2, 5'b00000, 2'b00, 4'b0001, 2'b10, 1'b0, 3'b010, 2'b00};
  localparam outs_t O_MRD   = {4'd3, 5'b10100, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam outs_t O_MWB   = {4'd4, 5'b00000, 2'b00, 4'b1010, 2'b00, 1'b0, 3'b000, 2'b10};
  localparam outs_t O_MWRW  = {4'd5, 5'b11100, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b00};
  localparam outs_t O_MWRG  = {4'd5, 5'b11100, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b10};
  localparam outs_t O_REX   = {4'd6, 5'b00000, 2'b00, 4'b0001, 2'b00, 1'b0, 3'b010, 2'b00};
  localparam outs_t O_RWB   = {4'd7, 5'b00000, 2'b00, 4'b1100, 2'b00, 1'b0, 3'b000, 2'b10};
  localparam outs_t O_IADD  = {4'd8, 5'b00000, 2'b00, 4'b0001, 2'b10, 1'b0, 3'b010, 2'b00};
  localparam outs_t O_IORI  = {4'd8, 5'b00000, 2'b00, 4'b0001, 2'b10, 1'b1, 3'b001, 2'b00};
  localparam outs_t O_ILUI  = {4'd8, 5'b00000, 2'b00, 4'b0001, 2'b10, 1'b1, 3'b000, 2'b00};
  localparam outs_t O_IWB   = {4'd9, 5'b00000, 2'b00, 4'b1000, 2'b00, 1'b0, 3'b000, 2'b10};
  localparam outs_t O_ILL   = {4'd10, 5'b00000, 2'b00, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b01};
  localparam outs_t O_JMP   = {4'd11, 5'b00001, 2'b10, 4'b0000, 2'b00, 1'b0, 3'b000, 2'b10};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ADDIU = 6'b001001;
  localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, RT = 6'b000000, JOP = 6'b000010;
  localparam logic [5:0] ADDU = 6'b100001, ADDF = 6'b100000;

  function automatic outs_t sample();
    return {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
            reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel,
            aluop, retire, illegal};
  endfunction

  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic mrdy, input outs_t exp, input string name);
    outs_t act;
    reset = rst; op = o; funct = f; mem_ready = mrdy;
    @(negedge clk);
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: state=%0d outs=%h", name, act.st, act);
    end
    n_checks++;
    if (ir_write && reg_write) begin
      n_errors++;
      $display("FAIL %s_onehot: ir_write=%b reg_write=%b want not both", name, ir_write, reg_write);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic mrdy, input outs_t exp, input string name);
    vec_t v;
    v.rst = rst; v.op = o; v.funct = f; v.mrdy = mrdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b1;

    add(1, LW, 0, 1, O_ZERO, "rst0");
    add(1, LW, 0, 1, O_ZERO, "rst1");
    add(0, LW, 0, 1, O_FG,   "lw_fetch");
    add(0, LW, 0, 1, O_DEC,  "lw_decode_ignore_rdy");
    add(0, LW, 0, 0, O_MADR, "lw_memadr");
    add(0, LW, 0, 0, O_MRD,  "lw_memrd_w1");
    add(0, LW, 0, 0, O_MRD,  "lw_memrd_w2");
    add(0, LW, 0, 1, O_MRD,  "lw_memrd_go");
    add(0, LW, 0, 0, O_MWB,  "lw_memwb");
    add(0, ORI, 0, 0, O_FW,  "fetch_wait");
    add(0, ORI, 0, 1, O_FG,  "ori_fetch");
    add(0, ORI, 0, 1, O_DEC, "ori_decode");
    add(0, ORI, 0, 1, O_IORI, "ori_iex");
    add(0, ORI, 0, 1, O_IWB, "ori_iwb");
    add(0, LUI, 0, 1, O_FG,  "lui_fetch");
    add(0, LUI, 0, 1, O_DEC, "lui_decode");
    add(0, LUI, 0, 1, O_ILUI, "lui_iex");
    add(0, LUI, 0, 1, O_IWB, "lui_iwb");
    add(0, ADDIU, 0, 1, O_FG,  "addiu_fetch");
    add(0, ADDIU, 0, 1, O_DEC, "addiu_decode");
    add(0, ADDIU, 0, 1, O_IADD, "addiu_iex");
    add(0, ADDIU, 0, 1, O_IWB, "addiu_iwb");
    add(0, RT, ADDU, 1, O_FG,  "addu_fetch");
    add(0, RT, ADDU, 1, O_DEC, "addu_decode");
    add(0, RT, ADDU, 1, O_REX, "addu_rex");
    add(0, RT, ADDU, 1, O_RWB, "addu_rwb");
    add(0, SW, 0, 1, O_FG,   "sw_fetch");
    add(0, SW, 0, 1, O_DEC,  "sw_decode");
    add(0, SW, 0, 0, O_MADR, "sw_memadr");
    add(0, SW, 0, 0, O_MWRW, "sw_memwr_wait");
    add(0, SW, 0, 1, O_MWRG, "sw_memwr_go");
    add(0, RT, ADDF, 1, O_FG,  "add_fetch");
    add(0, RT, ADDF, 1, O_DEC, "add_decode");
    add(0, RT, ADDF, 1, O_ILL, "add_illegal");

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].mrdy,
                           vecs[i].exp, vecs[i].name);

    // ILLEGAL must absorb regardless of inputs until reset.
    for (int k = 0; k < 10; k++)
      step(0, LW, 6'(k), k[0], O_ILL, $sformatf("illegal_hold%0d", k));
    step(1, LW, 0, 1, O_ZERO, "illegal_reset");
    step(0, SW, 0, 1, O_FG,   "post_ill_fetch");

    // Reset during a stalled store aborts it without retiring.
    step(0, SW, 0, 1, O_DEC,  "swr_decode");
    step(0, SW, 0, 0, O_MADR, "swr_memadr");
    step(0, SW, 0, 0, O_MWRW, "swr_memwr_wait");
    step(1, SW, 0, 0, O_ZERO, "swr_reset");
    step(0, JOP, 0, 1, O_FG,  "swr_restart_fetch");

    // Jump: third cycle either jumps or traps.
    step(0, JOP, 0, 1, O_DEC, "j_decode");
`ifdef MIPS_JUMP_EN
    step(0, JOP, 0, 1, O_JMP, "j_jump");
    step(0, ORI, 0, 1, O_FG,  "j_next_fetch");
`else
    step(0, JOP, 0, 1, O_ILL, "j_illegal");
    step(0, JOP, 0, 1, O_ILL, "j_illegal_hold");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded bound, want finish");
    $fatal(1, "timeout");
  end

endmodule
